// File: rtl/ef_bus_arb.sv
// ef_bus_arb: two-way round-robin arbiter and wait-state sequencer for the shared
// flash/Ethernet external bus, with per-device setup/strobe/hold and turnaround.
`default_nettype none

module ef_bus_arb #(
    parameter int AW     = 23,
    parameter int FL_TSU = 1,
    parameter int FL_TST = 3,
    parameter int FL_THD = 1,
    parameter int EN_TSU = 1,
    parameter int EN_TST = 2,
    parameter int EN_THD = 1,
    parameter int TTA    = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          fl_req,
    input  logic          fl_we,
    input  logic [AW-1:0] fl_adr,
    input  logic [31:0]   fl_wdt,
    output logic [31:0]   fl_rdt,
    output logic          fl_ack,
    input  logic          en_req,
    input  logic          en_we,
    input  logic [AW-1:0] en_adr,
    input  logic [31:0]   en_wdt,
    input  logic [3:0]    en_be_n,
    output logic [31:0]   en_rdt,
    output logic          en_ack,
    output logic [AW-1:0] ef_a,
    output logic [31:0]   ef_d_o,
    output logic          ef_d_oe,
    input  logic [31:0]   ef_d_i,
    output logic          flash_ce_n,
    output logic          flash_oe_n,
    output logic          flash_we_n,
    output logic          enet_rd_n,
    output logic          enet_wr_n,
    output logic [3:0]    enet_be_n
);

    localparam logic [3:0] FL_SU = 4'(FL_TSU);
    localparam logic [3:0] FL_ST = 4'(FL_TST);
    localparam logic [3:0] FL_HD = 4'(FL_THD);
    localparam logic [3:0] EN_SU = 4'(EN_TSU);
    localparam logic [3:0] EN_ST = 4'(EN_TST);
    localparam logic [3:0] EN_HD = 4'(EN_THD);
    localparam logic [3:0] TA    = 4'(TTA);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_SETUP  = 3'd1,
        S_STROBE = 3'd2,
        S_HOLD   = 3'd3,
        S_TURN   = 3'd4
    } state_t;

    state_t        state, nstate;
    logic [3:0]    cnt, ncnt;
    logic          last_en;
    logic          cur_en, cur_we;
    logic [AW-1:0] cur_adr;
    logic [31:0]   cur_wdt;
    logic [3:0]    cur_be;

    logic          fl_v, en_v, pick_en, grant, dev_en, strobe_end, active;
    logic          cap_we;
    logic [AW-1:0] cap_adr;
    logic [31:0]   cap_wdt;
    logic [3:0]    cap_be, tsu, tst, thd;

    always_comb begin
        // A requester is masked in its own ack cycle so a late-dropped req is not re-granted.
        fl_v    = fl_req & ~fl_ack;
        en_v    = en_req & ~en_ack;
        pick_en = en_v & (~fl_v | ~last_en);
        grant   = (state == S_IDLE) & (fl_v | en_v);
        dev_en  = grant ? pick_en : cur_en;
        tsu     = dev_en ? EN_SU : FL_SU;
        tst     = dev_en ? EN_ST : FL_ST;
        thd     = dev_en ? EN_HD : FL_HD;

        cap_adr = grant ? (pick_en ? en_adr  : fl_adr) : cur_adr;
        cap_we  = grant ? (pick_en ? en_we   : fl_we)  : cur_we;
        cap_wdt = grant ? (pick_en ? en_wdt  : fl_wdt) : cur_wdt;
        cap_be  = grant ? (pick_en ? en_be_n : 4'hF)   : cur_be;

        strobe_end = (state == S_STROBE) && (cnt == 4'd0);
        nstate     = state;
        ncnt       = (cnt == 4'd0) ? 4'd0 : cnt - 4'd1;

        case (state)
            S_IDLE: begin
                ncnt = 4'd0;
                if (grant) begin
                    if (tsu != 4'd0) begin
                        nstate = S_SETUP;
                        ncnt   = tsu - 4'd1;
                    end else begin
                        nstate = S_STROBE;
                        ncnt   = tst - 4'd1;
                    end
                end
            end
            S_SETUP: if (cnt == 4'd0) begin
                nstate = S_STROBE;
                ncnt   = tst - 4'd1;
            end
            S_STROBE: if (cnt == 4'd0) begin
                if (thd != 4'd0) begin
                    nstate = S_HOLD;
                    ncnt   = thd - 4'd1;
                end else if (TA != 4'd0) begin
                    nstate = S_TURN;
                    ncnt   = TA - 4'd1;
                end else begin
                    nstate = S_IDLE;
                end
            end
            S_HOLD: if (cnt == 4'd0) begin
                if (TA != 4'd0) begin
                    nstate = S_TURN;
                    ncnt   = TA - 4'd1;
                end else begin
                    nstate = S_IDLE;
                end
            end
            S_TURN: if (cnt == 4'd0) nstate = S_IDLE;
            default: begin
                nstate = S_IDLE;
                ncnt   = 4'd0;
            end
        endcase

        active = (nstate == S_SETUP) || (nstate == S_STROBE) || (nstate == S_HOLD);
    end

    // Pin levels are derived from the next state so every output comes straight off a flop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            cnt        <= 4'd0;
            last_en    <= 1'b1;
            cur_en     <= 1'b0;
            cur_we     <= 1'b0;
            cur_adr    <= '0;
            cur_wdt    <= 32'd0;
            cur_be     <= 4'hF;
            ef_a       <= '0;
            ef_d_o     <= 32'd0;
            ef_d_oe    <= 1'b0;
            flash_ce_n <= 1'b1;
            flash_oe_n <= 1'b1;
            flash_we_n <= 1'b1;
            enet_rd_n  <= 1'b1;
            enet_wr_n  <= 1'b1;
            enet_be_n  <= 4'hF;
            fl_rdt     <= 32'd0;
            en_rdt     <= 32'd0;
            fl_ack     <= 1'b0;
            en_ack     <= 1'b0;
        end else begin
            state <= nstate;
            cnt   <= ncnt;
            if (grant) begin
                last_en <= pick_en;
                cur_en  <= pick_en;
                cur_we  <= cap_we;
                cur_adr <= cap_adr;
                cur_wdt <= cap_wdt;
                cur_be  <= cap_be;
            end
            if (active) ef_a <= cap_adr;
            if (active && cap_we) ef_d_o <= cap_wdt;
            ef_d_oe    <= active && cap_we;
            flash_ce_n <= !(active && !dev_en);
            enet_be_n  <= (active && dev_en) ? cap_be : 4'hF;
            flash_oe_n <= !((nstate == S_STROBE) && !dev_en && !cap_we);
            flash_we_n <= !((nstate == S_STROBE) && !dev_en &&  cap_we);
            enet_rd_n  <= !((nstate == S_STROBE) &&  dev_en && !cap_we);
            enet_wr_n  <= !((nstate == S_STROBE) &&  dev_en &&  cap_we);
            fl_ack     <= strobe_end && !cur_en;
            en_ack     <= strobe_end &&  cur_en;
            if (strobe_end && !cur_we && !cur_en) fl_rdt <= ef_d_i;
            if (strobe_end && !cur_we &&  cur_en) en_rdt <= ef_d_i;
        end
    end

endmodule

`default_nettype wire
